// File: rtl/sbus_requester_if.sv
// SBUS memory-phase signals shared by a requester (master) and a memory (slave).
interface sbus_requester_if;
    logic         START_A;
    logic         START_B;
    logic [14:35] ADR;
    logic [0:3]   RQ;
    logic         ACKN_A;
    logic         ACKN_B;
    logic         DATA_VALID_A;
    logic         DATA_VALID_B;
    logic [0:35]  D;
    logic         DATA_PAR;

    modport master (
        output START_A, START_B, ADR, RQ,
        input  ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B, D, DATA_PAR
    );

    modport slave (
        input  START_A, START_B, ADR, RQ,
        output ACKN_A, ACKN_B, DATA_VALID_A, DATA_VALID_B, D, DATA_PAR
    );
endinterface

// File: rtl/sbus_requester.sv
// SBUS quadword read requester with slot tracking and NXM timeout.
// Define SBUS_PAR_CHK_EN to enable data parity checking on returned words.
module sbus_requester #(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          CROBAR_N,
    input  logic          reqValid,
    output logic          reqReady,
    input  logic [14:35]  reqAddr,
    input  logic [0:3]    reqMask,
    input  logic          reqPhaseB,
    sbus_requester_if.master sbus,
    output logic          rdValid,
    output logic [0:35]   rdData,
    output logic [34:35]  rdWo,
    output logic          rdParErr,
    output logic          done,
    output logic          nxm,
    output logic          protoErr
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t        state_reg;
    logic [14:35]  adr_reg;
    logic [0:3]    mask_reg;
    logic          phb_reg;
    logic [7:0]    cnt_reg;
    logic [1:0]    p_reg;
    logic          start_a_reg, start_b_reg;
    logic          rd_valid_reg, rd_par_reg;
    logic [0:35]   rd_data_reg;
    logic [1:0]    rd_wo_reg;
    logic          done_reg, nxm_reg, perr_reg;

    logic          ackn_sel, dv_sel, par_bad;
    logic [1:0]    lo_idx, hi_idx, slot_idx;
    logic          slot_err, last_slot, slot_active;

    function automatic logic [1:0] lowest(input logic [0:3] m);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) lowest = 2'(i);
    endfunction

    function automatic logic [1:0] highest(input logic [0:3] m);
        highest = 2'd0;
        for (int i = 0; i <= 3; i++)
            if (m[i]) highest = 2'(i);
    endfunction

    assign ackn_sel = phb_reg ? sbus.ACKN_B       : sbus.ACKN_A;
    assign dv_sel   = phb_reg ? sbus.DATA_VALID_B : sbus.DATA_VALID_A;

`ifdef SBUS_PAR_CHK_EN
    assign par_bad = (^sbus.D) ^ sbus.DATA_PAR;
`else
    logic par_unused;
    assign par_unused = sbus.DATA_PAR;
    assign par_bad    = 1'b0;
`endif

    // The ACKN slot is the lowest requested word; later slots follow p_reg.
    assign lo_idx      = lowest(mask_reg);
    assign hi_idx      = highest(mask_reg);
    assign slot_idx    = (state_reg == REQ) ? lo_idx : p_reg;
    assign slot_active = ((state_reg == REQ) && ackn_sel) || (state_reg == XFER);
    assign slot_err    = dv_sel ^ mask_reg[slot_idx];
    assign last_slot   = (slot_idx == hi_idx);

    always_ff @(posedge clk or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state_reg    <= IDLE;
            adr_reg      <= '0;
            mask_reg     <= '0;
            phb_reg      <= 1'b0;
            cnt_reg      <= '0;
            p_reg        <= '0;
            start_a_reg  <= 1'b0;
            start_b_reg  <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            rd_wo_reg    <= '0;
            rd_par_reg   <= 1'b0;
            done_reg     <= 1'b0;
            nxm_reg      <= 1'b0;
            perr_reg     <= 1'b0;
        end else begin
            rd_valid_reg <= 1'b0;
            done_reg     <= 1'b0;

            // Words are delivered even in unexpected slots; only the flag records it.
            if (slot_active && dv_sel) begin
                rd_valid_reg <= 1'b1;
                rd_data_reg  <= sbus.D;
                rd_wo_reg    <= adr_reg[34:35] + slot_idx;
                rd_par_reg   <= par_bad;
            end

            case (state_reg)
                IDLE: begin
                    if (reqValid) begin
                        nxm_reg  <= 1'b0;
                        perr_reg <= 1'b0;
                        cnt_reg  <= '0;
                        if (reqMask != 4'b0000) begin
                            adr_reg     <= reqAddr;
                            mask_reg    <= reqMask;
                            phb_reg     <= reqPhaseB;
                            start_a_reg <= ~reqPhaseB;
                            start_b_reg <= reqPhaseB;
                            state_reg   <= REQ;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (ackn_sel) begin
                        start_a_reg <= 1'b0;
                        start_b_reg <= 1'b0;
                        perr_reg    <= perr_reg | slot_err;
                        if (last_slot) begin
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            p_reg     <= slot_idx + 2'd1;
                            state_reg <= XFER;
                        end
                    end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                        start_a_reg <= 1'b0;
                        start_b_reg <= 1'b0;
                        nxm_reg     <= 1'b1;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                XFER: begin
                    perr_reg <= perr_reg | slot_err;
                    if (last_slot) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        p_reg <= p_reg + 2'd1;
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign reqReady     = (state_reg == IDLE);
    assign sbus.START_A = start_a_reg;
    assign sbus.START_B = start_b_reg;
    assign sbus.ADR     = adr_reg;
    assign sbus.RQ      = mask_reg;
    assign rdValid      = rd_valid_reg;
    assign rdData       = rd_data_reg;
    assign rdWo         = rd_wo_reg;
    assign rdParErr     = rd_par_reg;
    assign done         = done_reg;
    assign nxm          = nxm_reg;
    assign protoErr     = perr_reg;
endmodule

// File: tb/tb_sbus_requester.sv
// Directed bench for sbus_requester (TIMEOUT=8): quadword, wrap, sparse, timeout, parity, reset.
module tb_sbus_requester;
    logic          clk = 1'b0;
    logic          CROBAR_N;
    logic          reqValid;
    logic          reqReady;
    logic [14:35]  reqAddr;
    logic [0:3]    reqMask;
    logic          reqPhaseB;
    logic          rdValid;
    logic [0:35]   rdData;
    logic [34:35]  rdWo;
    logic          rdParErr;
    logic          done;
    logic          nxm;
    logic          protoErr;

    int checks = 0;
    int errors = 0;

`ifdef SBUS_PAR_CHK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    sbus_requester_if sbus ();

    sbus_requester #(.TIMEOUT(8)) dut (
        .clk(clk), .CROBAR_N(CROBAR_N),
        .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
        .reqMask(reqMask), .reqPhaseB(reqPhaseB),
        .sbus(sbus),
        .rdValid(rdValid), .rdData(rdData), .rdWo(rdWo), .rdParErr(rdParErr),
        .done(done), .nxm(nxm), .protoErr(protoErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:35] word_of(input int n, input int seed);
        return 36'h1_2345_6700 + 36'(seed << 4) + 36'(n);
    endfunction

    task automatic bus_idle();
        sbus.ACKN_A = 0; sbus.ACKN_B = 0;
        sbus.DATA_VALID_A = 0; sbus.DATA_VALID_B = 0;
        sbus.D = '0; sbus.DATA_PAR = 0;
    endtask

    task automatic drive_slot(input logic phb, input logic ack, input logic dv,
                              input logic [0:35] data, input logic flip);
        bus_idle();
        if (phb) begin sbus.ACKN_B = ack; sbus.DATA_VALID_B = dv; end
        else     begin sbus.ACKN_A = ack; sbus.DATA_VALID_A = dv; end
        sbus.D = data;
        sbus.DATA_PAR = (^data) ^ flip;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    // dv[n]/wo[2n+:2] describe slot n counted from the ACKN slot.
    task automatic xfer(input string tag, input logic [14:35] addr, input logic [0:3] mask,
                        input logic phb, input int lat, input int nslots,
                        input logic [0:3] dv, input logic [0:7] wo, input int flip,
                        input logic exp_proto, input int seed);
        reqValid = 1; reqAddr = addr; reqMask = mask; reqPhaseB = phb;
        chk({tag, ".ready"}, reqReady, 1);
        @(negedge clk);
        reqValid = 0;
        for (int c = 0; c < lat; c++) begin
            chk({tag, ".start"}, phb ? sbus.START_B : sbus.START_A, 1);
            chk({tag, ".other_start"}, phb ? sbus.START_A : sbus.START_B, 0);
            if (c == 0) begin
                chk({tag, ".adr"}, 36'(sbus.ADR), 36'(addr));
                chk({tag, ".rq"}, 36'(sbus.RQ), 36'(mask));
                chk({tag, ".busy"}, reqReady, 0);
            end
            if (c == lat - 1) drive_slot(phb, 1, dv[0], word_of(0, seed), flip == 0);
            @(negedge clk);
        end
        for (int n = 1; n <= nslots; n++) begin
            chk({tag, ".start_low"}, phb ? sbus.START_B : sbus.START_A, 0);
            chk({tag, ".other_start"}, phb ? sbus.START_A : sbus.START_B, 0);
            chk({tag, ".rdValid"}, rdValid, dv[n-1]);
            if (dv[n-1]) begin
                chk({tag, ".rdData"}, rdData, word_of(n-1, seed));
                chk({tag, ".rdWo"}, 36'(rdWo), 36'(wo[2*(n-1) +: 2]));
                chk({tag, ".rdParErr"}, rdParErr, PAR_EN && (flip == n-1));
            end
            chk({tag, ".done"}, done, n == nslots);
            if (n == nslots) begin
                chk({tag, ".nxm"}, nxm, 0);
                chk({tag, ".protoErr"}, protoErr, exp_proto);
                bus_idle();
            end else begin
                drive_slot(phb, 0, dv[n], word_of(n, seed), flip == n);
            end
            @(negedge clk);
        end
        chk({tag, ".done_end"}, done, 0);
        chk({tag, ".rdValid_end"}, rdValid, 0);
        chk({tag, ".ready_end"}, reqReady, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, reqReady, 1);
        chk({tag, ".start_a"}, sbus.START_A, 0);
        chk({tag, ".start_b"}, sbus.START_B, 0);
        chk({tag, ".adr"}, 36'(sbus.ADR), 0);
        chk({tag, ".rq"}, 36'(sbus.RQ), 0);
        chk({tag, ".rdValid"}, rdValid, 0);
        chk({tag, ".rdData"}, rdData, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".nxm"}, nxm, 0);
        chk({tag, ".protoErr"}, protoErr, 0);
    endtask

    initial begin
        CROBAR_N = 0; reqValid = 0; reqAddr = '0; reqMask = '0; reqPhaseB = 0;
        bus_idle();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        CROBAR_N = 1;
        @(negedge clk);

        // Full quadword, phase A, aligned: offsets 0,1,2,3.
        xfer("full", 22'h001004, 4'b1111, 0, 2, 4, 4'b1111, 8'b00_01_10_11, -1, 0, 1);
        // Wrap on phase B, address offset 2: offsets 2,3,0,1 (back-to-back accept).
        xfer("wrap", 22'h00ABC6, 4'b1111, 1, 3, 4, 4'b1111, 8'b10_11_00_01, -1, 0, 2);
        // Sparse [0:3]=0101 at offset 1: words 2 then 0, two clocks apart.
        xfer("sparse", 22'h000005, 4'b0101, 0, 1, 3, 4'b1010, 8'b10_00_00_00, -1, 0, 3);
        // Single word in slot 2 at offset 3: wraps to offset 1, ACKN slot is the last.
        xfer("single", 22'h00F00F, 4'b0010, 1, 1, 1, 4'b1000, 8'b01_00_00_00, -1, 0, 4);
        // Extra DATA_VALID in an unrequested slot: delivered, protoErr set.
        xfer("proto", 22'h000100, 4'b1010, 0, 1, 3, 4'b1110, 8'b00_01_10_00, -1, 1, 5);
        // Parity flipped on the second word only.
        xfer("parity", 22'h000200, 4'b1111, 0, 1, 4, 4'b1111, 8'b00_01_10_11, 1, 0, 6);
        // Clean request after the error request: protoErr must clear.
        xfer("clean", 22'h000300, 4'b1000, 0, 1, 1, 4'b1000, 8'b00_00_00_00, -1, 0, 7);

        // Empty mask: done next clock with no START.
        reqValid = 1; reqAddr = 22'h3FFFFF; reqMask = 4'b0000; reqPhaseB = 0;
        @(negedge clk);
        reqValid = 0;
        chk("empty.done", done, 1);
        chk("empty.nxm", nxm, 0);
        chk("empty.start", sbus.START_A | sbus.START_B, 0);
        chk("empty.rdValid", rdValid, 0);
        @(negedge clk);
        chk("empty.done_end", done, 0);
        chk("empty.ready", reqReady, 1);

        // Timeout: START held exactly 8 clocks, then done with nxm.
        reqValid = 1; reqAddr = 22'h123456; reqMask = 4'b1111; reqPhaseB = 0;
        @(negedge clk);
        reqValid = 0;
        for (int c = 0; c < 8; c++) begin
            chk("timeout.start", sbus.START_A, 1);
            chk("timeout.done_early", done, 0);
            chk("timeout.rdValid", rdValid, 0);
            @(negedge clk);
        end
        chk("timeout.start_low", sbus.START_A, 0);
        chk("timeout.done", done, 1);
        chk("timeout.nxm", nxm, 1);
        chk("timeout.rdValid_at_done", rdValid, 0);
        @(negedge clk);
        chk("timeout.ready", reqReady, 1);

        // Reset during XFER after the first word.
        reqValid = 1; reqAddr = 22'h000004; reqMask = 4'b1111; reqPhaseB = 0;
        @(negedge clk);
        reqValid = 0;
        drive_slot(0, 1, 1, word_of(0, 9), 0);
        @(negedge clk);
        chk("rst_mid.first_word", rdValid, 1);
        drive_slot(0, 0, 1, word_of(1, 9), 0);
        CROBAR_N = 0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        bus_idle();
        chk("rst_mid.no_done", done, 0);
        CROBAR_N = 1;
        @(negedge clk);
        xfer("after_rst", 22'h000007, 4'b1111, 1, 2, 4, 4'b1111, 8'b11_00_01_10, -1, 0, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
